// File: rtl/output_deskew.sv
// Output de-skew stage: re-aligns staggered systolic-array column results into full
// rows, buffers them in a small FIFO and hands them out over valid/ready with tile
// row tagging. Optional macro DESKEW_RELU_EN clamps negative elements to zero on write.
module output_deskew #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ROWS   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [N*DATA_W-1:0]         in_data,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [N*DATA_W-1:0]         row_data,
  output logic [$clog2(ROWS)+1-1:0]   row_idx,
  output logic                        row_last,
  output logic                        overflow,
  output logic                        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(ROWS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [N-2:0]          r_vld;
  logic                  w_aligned_valid;
  logic [N*DATA_W-1:0]   w_aligned_row;
  logic [N*DATA_W-1:0]   w_push_row;

  logic [N*DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_tile_idx;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  // The valid tag travels N-1 stages so it lines up with the last (undelayed) column.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < N - 1; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  assign w_aligned_valid = r_vld[N-2];

  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_direct
      assign w_aligned_row[j*DATA_W +: DATA_W] = in_data[j*DATA_W +: DATA_W];
    end else begin : g_delay
      localparam int L = N - 1 - j;
      logic [DATA_W-1:0] r_pipe [L];

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < L; k++) begin
            r_pipe[k] <= '0;
          end
        end else begin
          r_pipe[0] <= in_data[j*DATA_W +: DATA_W];
          for (int k = 1; k < L; k++) begin
            r_pipe[k] <= r_pipe[k-1];
          end
        end
      end

      assign w_aligned_row[j*DATA_W +: DATA_W] = r_pipe[L-1];
    end
  end

  // NOTE: default assignment first so every path drives w_push_row and no latch is inferred.
  always_comb begin
    w_push_row = w_aligned_row;
`ifdef DESKEW_RELU_EN
    for (int j = 0; j < N; j++) begin
      if (w_aligned_row[j*DATA_W + DATA_W - 1]) begin
        w_push_row[j*DATA_W +: DATA_W] = '0;
      end
    end
`endif
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && row_ready;
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign w_push  = w_aligned_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tile_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_tile_idx <= (r_tile_idx == LAST_IDX) ? '0 : r_tile_idx + IDX_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_aligned_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // NOTE: row storage is not reset; the cleared count masks it, and row_data reads 0 when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_row;
    end
  end

  assign row_valid = !w_empty;
  assign row_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign row_idx   = r_tile_idx;
  assign row_last  = !w_empty && (r_tile_idx == LAST_IDX);
  assign overflow  = r_overflow;
  assign busy      = (|r_vld) || !w_empty;

endmodule

// File: tb/tb_output_deskew.sv
// Directed bench for output_deskew (N=2, DATA_W=8, DEPTH=4, ROWS=2): a vector table
// for alignment/tile/ReLU cases plus hand sequences for backpressure, full+pop and reset.
module tb_output_deskew;

  localparam int N      = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ROWS   = 2;

`ifdef DESKEW_RELU_EN
  localparam logic [15:0] RELU_ROW = 16'h1000;
`else
  localparam logic [15:0] RELU_ROW = 16'h10F0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        row_valid;
  logic        row_ready;
  logic [15:0] row_data;
  logic [1:0]  row_idx;
  logic        row_last;
  logic        overflow;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  output_deskew #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [15:0] d;
    logic        rdy;
    logic        rv;
    logic [15:0] rd;
    logic [1:0]  idx;
    logic        last;
    logic        ovf;
    logic        bsy;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic rst_n_v, input logic iv, input logic [15:0] d, input logic rdy);
    @(negedge clk);
    reset     = rst_n_v;
    in_valid  = iv;
    in_data   = d;
    row_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic [15:0] rd,
                            input logic [1:0] idx, input logic last, input logic ovf,
                            input logic bsy);
    check({tag, ".row_valid"}, 32'(row_valid), 32'(rv));
    check({tag, ".row_data"},  32'(row_data),  32'(rd));
    check({tag, ".row_idx"},   32'(row_idx),   32'(idx));
    check({tag, ".row_last"},  32'(row_last),  32'(last));
    check({tag, ".overflow"},  32'(overflow),  32'(ovf));
    check({tag, ".busy"},      32'(busy),      32'(bsy));
  endtask

  initial begin
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] e0;
    logic [7:0] e1;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    row_ready = 1'b0;

    //            rst  iv   d         rdy   rv   rd        idx   last ovf  busy
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};
    // basic align: col0=05 at t, col1=07 at t+1, then held under backpressure
    vecs[1]  = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 16'h0700, 1'b1, 1'b1, 16'h0705, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0705, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1, 16'h0705, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};
    // tile of two rows (1,2) then (3,4) back-to-back
    vecs[7]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 16'h0203, 1'b1, 1'b1, 16'h0201, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0400, 1'b1, 1'b1, 16'h0403, 2'd1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};
    // negative element (F0) in column 0
    vecs[11] = '{1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 16'h1000, 1'b0, 1'b1, RELU_ROW,  2'd0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};

    step(1'b0, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst_n, vecs[i].iv, vecs[i].d, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rd, vecs[i].idx,
                 vecs[i].last, vecs[i].ovf, vecs[i].bsy);
    end

    // Backpressure: 4 rows fill the FIFO, a 5th is dropped, then drain in order.
    for (int c = 0; c < 6; c++) begin
      c0 = 8'h10 + 8'(c);
      c1 = (c >= 1) ? 8'h20 + 8'(c - 1) : 8'h00;
      step(1'b1, (c < 5), {c1, c0}, 1'b0);
      if (c >= 1) begin
        check_outs($sformatf("bp_fill%0d", c), 1'b1, 16'h2010, 2'd0, 1'b0, (c == 5), 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      if (i < 3) begin
        e0 = 8'h11 + 8'(i);
        e1 = 8'h21 + 8'(i);
        check_outs($sformatf("bp_drain%0d", i), 1'b1, {e1, e0}, 2'((i + 1) % 2),
                   ((i + 1) % 2 == 1), 1'b1, 1'b1);
      end else begin
        check_outs($sformatf("bp_drain%0d", i), 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0);
      end
    end

    // Reset mid-operation: 2 rows buffered, 1 in the delay line, tile index 1, overflow set.
    step(1'b1, 1'b1, 16'h0050, 1'b0);
    step(1'b1, 1'b1, 16'h6051, 1'b0);
    step(1'b1, 1'b1, 16'h6152, 1'b1);
    step(1'b1, 1'b1, 16'h6253, 1'b0);
    check_outs("pre_reset", 1'b1, 16'h6151, 2'd1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h6300, 1'b0);
    check_outs("mid_reset", 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h6300, 1'b1);
      check_outs($sformatf("post_reset%0d", i), 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Full FIFO with simultaneous pop: the aligning row is accepted, count stays 4.
    for (int c = 0; c < 6; c++) begin
      c0 = 8'h30 + 8'(c);
      c1 = (c >= 1) ? 8'h40 + 8'(c - 1) : 8'h00;
      step(1'b1, (c < 5), {c1, c0}, (c == 5));
      if (c == 4) check_outs("fp_full", 1'b1, 16'h4030, 2'd0, 1'b0, 1'b0, 1'b1);
      if (c == 5) check_outs("fp_pushpop", 1'b1, 16'h4131, 2'd1, 1'b1, 1'b0, 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      if (j < 3) begin
        e0 = 8'h32 + 8'(j);
        e1 = 8'h42 + 8'(j);
        check_outs($sformatf("fp_drain%0d", j), 1'b1, {e1, e0}, 2'(j % 2), (j % 2 == 1),
                   1'b0, 1'b1);
      end else begin
        check_outs($sformatf("fp_drain%0d", j), 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
